// File: rtl/cs_seq_multi_if.sv
// Handshake bundle between the multi-device sequencer and its
// MAC, FIFO, ADC and UDP neighbours.
interface cs_seq_multi_if #(
  parameter int unsigned NUM_DEV = 4
);
  logic               fs_adc;
  logic               fs_udp_rx;
  logic               fd_udp_rx;
  logic               fs_mac2fifoc;
  logic               fd_mac2fifoc;
  logic               fs_fifoc2cs;
  logic               fd_fifoc2cs;
  logic [7:0]         cmd_kdev;
  logic [7:0]         cmd_ctrl;
  logic [NUM_DEV-1:0] fs_adc_check;
  logic [NUM_DEV-1:0] fd_adc_check;
  logic [NUM_DEV-1:0] fs_adc_conf;
  logic [NUM_DEV-1:0] fd_adc_conf;
  logic [NUM_DEV-1:0] fs_adc_read;
  logic [NUM_DEV-1:0] fd_adc_read;
  logic               fs_adc_fifo;
  logic               fd_adc_fifo;
  logic               fs_udp_tx;
  logic               fd_udp_tx;
  logic [NUM_DEV-1:0] dev_mask;
  logic [11:0]        eth_tx_len;
  logic               rst_dev;
  logic               err;
  logic               ovr;
  logic [3:0]         state;

  modport master (
    input  fs_adc, fs_udp_rx,
    input  fd_mac2fifoc, fd_fifoc2cs,
    input  cmd_kdev, cmd_ctrl,
    input  fd_adc_check, fd_adc_conf,
    input  fd_adc_read, fd_adc_fifo,
    input  fd_udp_tx,
    output fd_udp_rx,
    output fs_mac2fifoc, fs_fifoc2cs,
    output fs_adc_check, fs_adc_conf,
    output fs_adc_read, fs_adc_fifo,
    output fs_udp_tx,
    output dev_mask, eth_tx_len,
    output rst_dev, err, ovr, state
  );

  modport slave (
    output fs_adc, fs_udp_rx,
    output fd_mac2fifoc, fd_fifoc2cs,
    output cmd_kdev, cmd_ctrl,
    output fd_adc_check, fd_adc_conf,
    output fd_adc_read, fd_adc_fifo,
    output fd_udp_tx,
    input  fd_udp_rx,
    input  fs_mac2fifoc, fs_fifoc2cs,
    input  fs_adc_check, fs_adc_conf,
    input  fs_adc_read, fs_adc_fifo,
    input  fs_udp_tx,
    input  dev_mask, eth_tx_len,
    input  rst_dev, err, ovr, state
  );
endinterface

// File: rtl/cs_seq_multi.sv
// Multi-device command/status sequencer: command intake, per-device
// check/config, then one read/fifo/tx cycle per sample tick.
module cs_seq_multi #(
  parameter int unsigned      NUM_DEV = 4,
  parameter int unsigned      ADC_LEN = 64,
  parameter int unsigned      HDR_LEN = 8,
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = 16'hFFFF
) (
  input logic            clk,
  input logic            rst,
  cs_seq_multi_if.master bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RXACK     = 4'd1,
    MAC2FIFOC = 4'd2,
    FIFOC2CS  = 4'd3,
    DECODE    = 4'd4,
    CHECK     = 4'd5,
    CONF      = 4'd6,
    WAIT      = 4'd7,
    READ      = 4'd8,
    FIFO      = 4'd9,
    TX        = 4'd10
  } state_t;

  state_t             cur, nxt;
  logic [TMO_W-1:0]   cnt, cnt_d;
  logic               run, run_d;
  logic [NUM_DEV-1:0] mask, mask_d;
  logic [NUM_DEV-1:0] kdev, fd_v;
  logic [NUM_DEV-1:0] chk_q, chk_d;
  logic [NUM_DEV-1:0] conf_q, conf_d;
  logic [NUM_DEV-1:0] rd_q, rd_d;
  logic [11:0]        len_q, len_d, len_sat;
  logic [31:0]        len_w;
  logic [3:0]         pop;
  logic               waiting, vdone, tmo_hit, rx_entry;
  logic               fdrx_q, fdrx_d;
  logic               mac_q, mac_d;
  logic               fc_q, fc_d;
  logic               fifo_q, fifo_d;
  logic               tx_q, tx_d;
  logic               rdev_q, rdev_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;
  logic               unused_bits;

  assign kdev        = bus.cmd_kdev[NUM_DEV-1:0];
  assign unused_bits = ^{bus.cmd_ctrl[7:2], bus.cmd_kdev};

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_DEV; i++)
      pop = pop + {3'b000, kdev[i]};
  end

  assign len_w   = HDR_LEN + 32'(pop) * ADC_LEN;
  assign len_sat = (len_w > 32'hFFF) ? 12'hFFF : len_w[11:0];

  always_comb begin
    fd_v = bus.fd_adc_read;
    if (cur == CHECK)
      fd_v = bus.fd_adc_check;
    else if (cur == CONF)
      fd_v = bus.fd_adc_conf;
  end

  // disabled devices never hold a vector stage back
  assign vdone   = (fd_v & mask) == mask;
  assign waiting = cur inside {RXACK, MAC2FIFOC, FIFOC2CS,
                               CHECK, CONF, READ, FIFO, TX};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur    <= IDLE;
      cnt    <= '0;
      run    <= 1'b0;
      mask   <= '0;
      len_q  <= '0;
      chk_q  <= '0;
      conf_q <= '0;
      rd_q   <= '0;
      fdrx_q <= 1'b0;
      mac_q  <= 1'b0;
      fc_q   <= 1'b0;
      fifo_q <= 1'b0;
      tx_q   <= 1'b0;
      rdev_q <= 1'b0;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cur    <= nxt;
      cnt    <= cnt_d;
      run    <= run_d;
      mask   <= mask_d;
      len_q  <= len_d;
      chk_q  <= chk_d;
      conf_q <= conf_d;
      rd_q   <= rd_d;
      fdrx_q <= fdrx_d;
      mac_q  <= mac_d;
      fc_q   <= fc_d;
      fifo_q <= fifo_d;
      tx_q   <= tx_d;
      rdev_q <= rdev_d;
      err_q  <= err_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    nxt     = cur;
    tmo_hit = 1'b0;
    unique case (cur)
      IDLE:      if (bus.fs_udp_rx) nxt = RXACK;
      RXACK:     if (!bus.fs_udp_rx) nxt = MAC2FIFOC;
      MAC2FIFOC: if (bus.fd_mac2fifoc) nxt = FIFOC2CS;
      FIFOC2CS:  if (bus.fd_fifoc2cs) nxt = DECODE;
      DECODE:    nxt = (kdev == '0) ? IDLE : CHECK;
      CHECK:     if (vdone) nxt = CONF;
      CONF:      if (vdone) nxt = run ? WAIT : IDLE;
      WAIT: begin
        if (bus.fs_udp_rx)   nxt = RXACK;
        else if (bus.fs_adc) nxt = READ;
      end
      READ:      if (vdone) nxt = FIFO;
      FIFO:      if (bus.fd_adc_fifo) nxt = TX;
      TX:        if (bus.fd_udp_tx) nxt = WAIT;
      default:   nxt = IDLE;
    endcase
    if (waiting && nxt == cur && cnt == TMO_MAX) begin
      nxt     = IDLE;
      tmo_hit = 1'b1;
    end
  end

  always_comb begin
    rx_entry = (nxt == RXACK) && (cur != RXACK);
    cnt_d    = (nxt != cur) ? '0 :
               waiting ? cnt + TMO_W'(1) : cnt;
    mask_d   = (cur == DECODE) ? kdev : mask;
    run_d    = (cur == DECODE) ? bus.cmd_ctrl[0] : run;
    len_d    = len_q;
    if (cur == DECODE)
      len_d = (kdev == '0) ? 12'h000 : len_sat;
    rdev_d   = (cur == DECODE) && bus.cmd_ctrl[1];
    // strobes are a function of the state being entered
    fdrx_d   = nxt == RXACK;
    mac_d    = nxt == MAC2FIFOC;
    fc_d     = nxt == FIFOC2CS;
    chk_d    = (nxt == CHECK) ? mask_d : '0;
    conf_d   = (nxt == CONF) ? mask_d : '0;
    rd_d     = (nxt == READ) ? mask_d : '0;
    fifo_d   = nxt == FIFO;
    tx_d     = nxt == TX;
    err_d    = tmo_hit ? 1'b1 : rx_entry ? 1'b0 : err_q;
    ovr_d    = ovr_q;
    if (rx_entry)
      ovr_d = 1'b0;
    else if (bus.fs_adc && (cur inside {READ, FIFO, TX}))
      ovr_d = 1'b1;
  end

  assign bus.fd_udp_rx    = fdrx_q;
  assign bus.fs_mac2fifoc = mac_q;
  assign bus.fs_fifoc2cs  = fc_q;
  assign bus.fs_adc_check = chk_q;
  assign bus.fs_adc_conf  = conf_q;
  assign bus.fs_adc_read  = rd_q;
  assign bus.fs_adc_fifo  = fifo_q;
  assign bus.fs_udp_tx    = tx_q;
  assign bus.dev_mask     = mask;
  assign bus.eth_tx_len   = len_q;
  assign bus.rst_dev      = rdev_q;
  assign bus.err          = err_q;
  assign bus.ovr          = ovr_q;
  assign bus.state        = cur;

endmodule
